// File: rtl/morse_sequencer.sv
`timescale 1ns/1ps
// morse_sequencer
//
// Plays the 8-slot Morse pattern from the digit encoder on the buzzer pin.
// A rising edge on sound_begin latches the 144-bit code into a shadow
// register. The block then walks the slots one Morse unit at a time.
// Each unit drives either a square-wave tone or silence on beep.
//
// Ports:
//   clk          - system clock
//   rst          - asynchronous active-high reset
//   code         - eight 18-bit slots; slot k is code[143-18k -: 18].
//                  Only bits [13:0] of a slot are used, played MSB first.
//   switches     - tone select. The highest set bit picks the pitch.
//                  All zeros mutes the tone.
//   speed_adjust - 1 selects half-length (fast) units
//   sound_begin  - start request (rising edge)
//   beep         - registered buzzer drive
//   playing      - registered, high while the sequencer is not idle
//
// Optional feature:
//   MORSE_REPEAT_EN - loop the latched pattern forever. Another start edge
//                     finishes the current unit and then stops.
module morse_sequencer #(
  parameter int unsigned UNIT_CYCLES = 25_000_000,
  parameter int unsigned TONE_HALF   = 50_000,
  parameter int unsigned TONE_STEP   = 5_000,
  parameter int unsigned GAP_UNITS   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [143:0] code,
  input  logic [8:0]   switches,
  input  logic         speed_adjust,
  input  logic         sound_begin,
  output logic         beep,
  output logic         playing
);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_UNIT, S_GAP, S_END} state_t;

  state_t      state, state_next;
  logic        sb_q;
  logic [13:0] pat_q [8];
  logic [2:0]  slot;
  logic [3:0]  bit_idx;
  logic [31:0] unit_cnt;
  logic [31:0] unit_len_q;
  logic [31:0] gap_cnt;
  logic [31:0] tone_cnt;
  logic [31:0] half_q;
  logic        tone_q;

  logic        start;
  logic        stop;
  logic [13:0] slot_pat;
  logic        cur_bit;
  logic        last_slot;
  logic [3:0]  sw_idx;
  logic [31:0] half_now, half_eff;
  logic [31:0] ulen_now, ulen_eff;
  logic        audible_now, audible_eff;
  logic        unit_first, unit_last;

  // The slot bits [17:14] carry nothing for this block.
  logic unused_code_bits;
  assign unused_code_bits = ^{code[143:140], code[125:122], code[107:104], code[89:86],
                              code[71:68], code[53:50], code[35:32], code[17:14]};

  assign start     = sound_begin & ~sb_q;
  assign slot_pat  = pat_q[slot];
  assign cur_bit   = slot_pat[bit_idx];
  assign last_slot = (slot == 3'd7);

  // Highest set switch wins; a later (higher) index overrides lower ones.
  always_comb begin
    sw_idx = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (switches[i]) sw_idx = 4'(i);
    end
  end

  assign half_now    = 32'(TONE_HALF) + 32'(sw_idx) * 32'(TONE_STEP);
  assign ulen_now    = speed_adjust ? 32'(UNIT_CYCLES >> 1) : 32'(UNIT_CYCLES);
  assign audible_now = cur_bit & (|switches);

  // Length, pitch and mute are sampled on a unit's first cycle and held in
  // registers for the remainder. The live values are used on that first cycle.
  assign unit_first  = (unit_cnt == 32'd0);
  assign ulen_eff    = unit_first ? ulen_now : unit_len_q;
  assign half_eff    = unit_first ? half_now : half_q;
  assign audible_eff = unit_first ? audible_now : tone_q;
  // The >= form also treats a zero-length unit as one cycle.
  assign unit_last   = (unit_cnt + 32'd1 >= ulen_eff);

`ifdef MORSE_REPEAT_EN
  logic stop_q;

  // A start edge during play is remembered until the block is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop_q <= 1'b0;
    end else if (state == S_IDLE) begin
      stop_q <= 1'b0;
    end else if (start) begin
      stop_q <= 1'b1;
    end
  end

  assign stop = stop_q | (start & (state != S_IDLE));
`else
  assign stop = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_SCAN;
      end
      S_SCAN: begin
        if (stop)                state_next = S_END;
        else if (slot_pat != '0) state_next = S_UNIT;
        else if (last_slot)      state_next = S_END;
      end
      S_UNIT: begin
        if (unit_last) begin
          if (stop) begin
            state_next = S_END;
          end else if (bit_idx == 4'd0) begin
            if (GAP_UNITS == 0) state_next = last_slot ? S_END : S_SCAN;
            else                state_next = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (unit_last) begin
          if (stop)                                   state_next = S_END;
          else if (gap_cnt == 32'(GAP_UNITS - 1))     state_next = last_slot ? S_END : S_SCAN;
        end
      end
      S_END: begin
`ifdef MORSE_REPEAT_EN
        state_next = stop ? S_IDLE : S_SCAN;
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  // beep defaults to 0 every cycle. Only a running tone unit keeps it or
  // toggles it. That gives the forced 0 after each unit and in every other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q       <= 1'b0;
      playing    <= 1'b0;
      beep       <= 1'b0;
      slot       <= '0;
      bit_idx    <= '0;
      unit_cnt   <= '0;
      unit_len_q <= '0;
      gap_cnt    <= '0;
      tone_cnt   <= '0;
      half_q     <= '0;
      tone_q     <= 1'b0;
      for (int k = 0; k < 8; k++) pat_q[k] <= '0;
    end else begin
      sb_q    <= sound_begin;
      playing <= (state_next != S_IDLE);
      beep    <= 1'b0;

      if (state == S_IDLE && start) begin
        for (int k = 0; k < 8; k++) pat_q[k] <= code[139 - 18*k -: 14];
      end

      if (state_next == S_SCAN) begin
        slot <= (state == S_IDLE || state == S_END) ? 3'd0 : slot + 3'd1;
      end

      case (state)
        S_SCAN: begin
          bit_idx  <= 4'd13;
          unit_cnt <= '0;
          tone_cnt <= '0;
        end
        S_UNIT, S_GAP: begin
          if (unit_first) begin
            unit_len_q <= ulen_now;
            half_q     <= half_now;
            tone_q     <= audible_now;
          end
          if (unit_last) begin
            unit_cnt <= '0;
            tone_cnt <= '0;
            if (state == S_UNIT) begin
              bit_idx <= bit_idx - 4'd1;
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt + 32'd1;
            end
          end else begin
            unit_cnt <= unit_cnt + 32'd1;
            if (state == S_UNIT && audible_eff) begin
              if (tone_cnt + 32'd1 >= half_eff) begin
                beep     <= ~beep;
                tone_cnt <= '0;
              end else begin
                beep     <= beep;
                tone_cnt <= tone_cnt + 32'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/morse_sequencer.md
# morse_sequencer

Plays the 8-slot Morse bit pattern produced by the digit encoder on the buzzer pin. It latches the 144-bit code vector on a start request and walks the slots unit by unit. For each unit it drives a square-wave tone or silence. Tone pitch is set by the switches and unit length by the speed input. It sits directly downstream of the encoder and is the only block driving `beep`.

## Interface
Parameters:
- `UNIT_CYCLES`, default 25_000_000: clock cycles per Morse time unit at normal speed.
- `TONE_HALF`, default 50_000: tone half-period in cycles for switch index 0.
- `TONE_STEP`, default 5_000: half-period increment per switch index.
- `GAP_UNITS`, default 3: silent units appended after each non-blank slot.

Ports:
- `clk`, in, 1: system clock. One clock only.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `code`, in, 144: eight 18-bit slots. Slot k occupies `code[143-18k -: 18]`. Bits [17:14] of each slot are ignored; bits [13:0] are the pattern, played MSB first.
- `switches`, in, 9: tone select.
- `speed_adjust`, in, 1: 1 selects fast units (`UNIT_CYCLES>>1`).
- `sound_begin`, in, 1: start request, level; its rising edge is used.
- `beep`, out, 1: buzzer drive. Registered.
- `playing`, out, 1: high while not IDLE. Registered.

## Operation
- Reset values: `beep`=0, `playing`=0, state IDLE, shadow code register 0, edge register 0.
- Start detection:
  - `sb_q` registers `sound_begin` every cycle.
  - `start` = `sound_begin & ~sb_q`.
- States:
  - IDLE. On `start`: latch `code` into the shadow register, set slot=0, go to SCAN. No other transitions.
  - SCAN (1 cycle per slot). If pattern bits [13:0] of the current slot are nonzero: bit index=13, go to UNIT. Otherwise advance the slot; if slot 7 was just scanned, go to END.
  - UNIT. Lasts U cycles, where U is `speed_adjust` sampled on the unit's first cycle. The tone is enabled iff the pattern bit is 1. After bit 0, go to GAP.
  - GAP. Lasts `GAP_UNITS` units of silence. Then advance the slot and go to SCAN; after slot 7, go to END.
  - END (1 cycle). Go to IDLE.
- Pattern bits are played as-is: `110` is a dash, `10` is a dot. Trailing zeros are played as silence before GAP.
- The shadow register is used for the whole pass. Changes on `code` during play have no effect.
- `start` while not IDLE is ignored (except with the repeat feature, see Configuration).
- Tone selection:
  - i = index of the highest set bit of `switches`.
  - Half-period H = `TONE_HALF + i*TONE_STEP`.
  - `switches`==0 means mute: `beep` stays 0 but timing is unchanged.
  - `switches` is sampled on each UNIT's first cycle.
- Tone generation:
  - In a tone-enabled unit, `beep` starts at 0 and toggles every H cycles.
  - `beep` is forced to 0 in the cycle after any tone unit ends and in all other states.
- Counters are 32-bit unsigned. The unit counter reloads at every unit boundary; no carry crosses units.

## Timing
- `start` seen in cycle c: `playing`=1 and state=SCAN from cycle c+1.
- First UNIT starts at c+2 if slot 0 is non-blank.
- In a tone unit starting at cycle t, the first `beep` rise is at t+H.
- Each blank slot costs exactly 1 cycle.
- Single-pass length: 8 SCAN cycles, plus (14+`GAP_UNITS`)×U per non-blank slot, plus 1 END cycle.
- `rst` asserted mid-play: `beep` and `playing` go 0 immediately (asynchronous). State returns to IDLE.
- Holding `sound_begin` high does not restart play. A new low-to-high transition is required.

## Configuration
- `MORSE_REPEAT_EN` defined: after END, the block returns to SCAN at slot 0 instead of IDLE, using the same shadow code, and loops indefinitely. A `start` edge during play finishes the current unit, then goes to END and IDLE with `beep`=0.
- `MORSE_REPEAT_EN` undefined: single pass; `start` during play is ignored.

## Test plan
Parameters for all scenarios: `UNIT_CYCLES`=8, `TONE_HALF`=2, `TONE_STEP`=1, `GAP_UNITS`=3.

- Single digit, `switches`=9'b1:
  - Stimulus: slot0 = `0000_10101010100000` (digit 5), others 0, then a `sound_begin` pulse.
  - Required: `playing` high for 1+17×8+7+1 = 145 cycles.
  - `beep` toggles with period 4 in units 0,2,4,6,8 and is 0 elsewhere.
- All slots blank:
  - Required: `playing` high for exactly 9 cycles (8 SCAN + 1 END); `beep` never rises.
- Mid-play changes:
  - Stimulus: `code` changed and `speed_adjust` set to 1 mid-play.
  - Required: the pattern is unchanged (shadow register); units starting after the change last 4 cycles.
- Mute and pitch:
  - `switches`=0: `playing` has identical duration, `beep` stays 0.
  - `switches`=9'b1_0000_0000: H=10.
- Reset and re-start:
  - `rst` pulse mid-UNIT: `beep`=0 and `playing`=0 within the same cycle.
  - A second `sound_begin` rising edge during play is ignored without the macro.
- Repeat (`MORSE_REPEAT_EN` defined):
  - After END the block re-enters SCAN slot 0.
  - A `sound_begin` edge stops play after the current unit.
